// File: rtl/axi4w_arb.sv
// Round-robin arbiter merging NUM_REQ AXI4 W-channel requesters onto one slave port; grant held for a whole burst.
// Optional macro AXI4W_ARB_BEAT_LIMIT_EN adds a sticky beat-limit error on err_o.
module axi4w_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ*DATA_W-1:0]    s_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]  s_wstrb,
  input  logic [NUM_REQ-1:0]           s_wlast,
  input  logic [NUM_REQ-1:0]           s_wvalid,
  output logic [NUM_REQ-1:0]           s_wready,
  output logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_wlast,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 16 || (DATA_W % 8) != 0 || MAX_BEATS < 2) begin : g_param_err
    $error("axi4w_arb: illegal parameter set");
  end

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [PTR_W-1:0]   r_gidx, w_gidx_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_nxt;
  logic               w_found;
  logic [PTR_W-1:0]   w_sel;
  logic               w_hs;

  // First asserted wvalid scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin : p_pick
    logic [PTR_W:0] v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      v_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (v_idx >= (PTR_W+1)'(NUM_REQ)) begin
        v_idx = v_idx - (PTR_W+1)'(NUM_REQ);
      end
      if (!w_found && s_wvalid[PTR_W'(v_idx)]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'(v_idx);
      end
    end
  end

  assign w_hs = m_wvalid & m_wready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_gidx   <= w_gidx_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Next-state: grant in IDLE, release only on the wlast handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_BURST;
          w_grant_nxt = NUM_REQ'(1) << w_sel;
          w_gidx_nxt  = w_sel;
        end
      end
      S_BURST: begin
        if (w_hs && m_wlast) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_rr_nxt    = (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Output mux: zero-latency path from the granted requester, all-zero when idle.
  always_comb begin
    m_wdata  = '0;
    m_wstrb  = '0;
    m_wlast  = 1'b0;
    m_wvalid = 1'b0;
    s_wready = '0;
    if (r_state == S_BURST) begin
      m_wdata          = s_wdata[int'(r_gidx)*DATA_W +: DATA_W];
      m_wstrb          = s_wstrb[int'(r_gidx)*STRB_W +: STRB_W];
      m_wlast          = s_wlast[r_gidx];
      m_wvalid         = s_wvalid[r_gidx];
      s_wready[r_gidx] = m_wready;
    end
  end

  assign grant_o = r_grant;
  assign busy_o  = (r_state == S_BURST);

`ifdef AXI4W_ARB_BEAT_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_err;

  // Beats of the current burst; a non-final beat at MAX_BEATS-1 means the burst overruns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_beat_cnt <= '0;
      end else if (w_hs) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
      if (w_hs && !m_wlast && r_beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi4w_arb.sv
// Scoreboard bench for axi4w_arb: requester drivers feed bursts, expected beats are queued at post time.
module tb_axi4w_arb;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int SW = 4;
`ifdef AXI4W_ARB_BEAT_LIMIT_EN
  localparam int MB  = 4;
  localparam bit LIM = 1'b1;
`else
  localparam int MB  = 256;
  localparam bit LIM = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic [NR-1:0] gnt;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic [NR*DW-1:0]  s_wdata;
  logic [NR*SW-1:0]  s_wstrb;
  logic [NR-1:0]     s_wlast;
  logic [NR-1:0]     s_wvalid;
  logic [NR-1:0]     s_wready;
  logic [DW-1:0]     m_wdata;
  logic [SW-1:0]     m_wstrb;
  logic              m_wlast;
  logic              m_wvalid;
  logic              m_wready;
  logic [NR-1:0]     grant_o;
  logic              busy_o;
  logic              err_o;

  logic              force_v;
  logic [DW-1:0]     d_data [NR];
  logic [SW-1:0]     d_strb [NR];
  logic              d_last [NR];
  logic              d_valid[NR];

  beat_t req_q[NR][$];
  int    gap_q[NR][$];
  beat_t exp_q[$];

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  axi4w_arb #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-requester driver: advances on the handshake sampled at negedge, updates #1 after posedge.
  for (genvar g = 0; g < NR; g++) begin : g_drv
    assign s_wdata[g*DW +: DW] = d_data[g];
    assign s_wstrb[g*SW +: SW] = d_strb[g];
    assign s_wlast[g]          = d_last[g];
    assign s_wvalid[g]         = d_valid[g] | force_v;

    initial begin
      bit hs_n;
      d_valid[g] = 1'b0;
      d_data[g]  = '0;
      d_strb[g]  = '0;
      d_last[g]  = 1'b0;
      forever begin
        @(negedge clk);
        hs_n = d_valid[g] && s_wready[g];
        @(posedge clk);
        #1;
        if (hs_n && req_q[g].size() > 0) begin
          void'(req_q[g].pop_front());
          void'(gap_q[g].pop_front());
        end
        if (req_q[g].size() == 0) begin
          d_valid[g] = 1'b0;
        end else if (gap_q[g][0] > 0) begin
          gap_q[g][0] = gap_q[g][0] - 1;
          d_valid[g]  = 1'b0;
        end else begin
          d_valid[g] = 1'b1;
          d_data[g]  = req_q[g][0].data;
          d_strb[g]  = req_q[g][0].strb;
          d_last[g]  = req_q[g][0].last;
        end
      end
    end
  end

  task automatic post_burst(input int r, input int n, input logic [DW-1:0] base, input int gap2);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + DW'(i);
      b.strb = SW'(i + 1) ^ base[SW-1:0];
      b.last = (i == n - 1);
      b.gnt  = NR'(1) << r;
      req_q[r].push_back(b);
      gap_q[r].push_back((i == 1) ? gap2 : 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    force_v  = 1'b0;
    m_wready = 1'b1;
    for (int r = 0; r < NR; r++) begin
      req_q[r].delete();
      gap_q[r].delete();
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    force_v = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({grant_o, busy_o, m_wvalid, s_wready, err_o} !== '0)
        $display("FAIL reset: grant=%b busy=%b m_wvalid=%b s_wready=%b err=%b, all required 0",
                 grant_o, busy_o, m_wvalid, s_wready, err_o);
      else passed++;
    end
    force_v = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic test_single();
    beat_t e;
    apply_reset();
    post_burst(2, 4, 32'h0000_00A0, 0);
    @(negedge clk);
    total++;
    if (grant_o !== 4'b0000) $display("FAIL single_pre_grant: grant=%b required 0000", grant_o);
    else passed++;
    @(negedge clk);
    total++;
    if (grant_o !== 4'b0100 || busy_o !== 1'b1)
      $display("FAIL single_grant: grant=%b busy=%b required 0100/1", grant_o, busy_o);
    else passed++;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (m_wvalid && m_wready) begin
        e = exp_q.pop_front();
        total++;
        if ({m_wdata, m_wstrb, m_wlast, grant_o} !== {e.data, e.strb, e.last, e.gnt})
          $display("FAIL single_beat: got d=%h s=%h l=%b g=%b required d=%h s=%h l=%b g=%b",
                   m_wdata, m_wstrb, m_wlast, grant_o, e.data, e.strb, e.last, e.gnt);
        else passed++;
      end
      @(negedge clk);
    end
    total++;
    if (exp_q.size() != 0 || busy_o !== 1'b0 || grant_o !== '0)
      $display("FAIL single_release: left=%0d busy=%b grant=%b required 0/0/0000",
               exp_q.size(), busy_o, grant_o);
    else passed++;
  endtask

  task automatic test_contention();
    beat_t e;
    int g0, last_cyc, idle;
    apply_reset();
    for (int r = 0; r < NR; r++) post_burst(r, 2, DW'(32'h100 * (r + 1)), 0);
    for (int c = 0; c < 6 && grant_o == '0; c++) @(negedge clk);
    total++;
    if (grant_o !== 4'b0001) $display("FAIL cont_first_grant: grant=%b required 0001", grant_o);
    else passed++;
    g0 = cyc;
    last_cyc = -100;
    idle = 0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (!busy_o) idle++;
      if (m_wvalid && m_wready) begin
        e = exp_q.pop_front();
        if (e.last) last_cyc = cyc;
        total++;
        if ({m_wdata, m_wstrb, m_wlast, grant_o} !== {e.data, e.strb, e.last, e.gnt})
          $display("FAIL cont_beat: got d=%h s=%h l=%b g=%b required d=%h s=%h l=%b g=%b",
                   m_wdata, m_wstrb, m_wlast, grant_o, e.data, e.strb, e.last, e.gnt);
        else passed++;
      end
      @(negedge clk);
    end
    total++;
    if (exp_q.size() != 0 || (last_cyc + 1 - g0) != 11 || idle != 3)
      $display("FAIL cont_timing: left=%0d span=%0d idle=%0d required 0/11/3",
               exp_q.size(), last_cyc + 1 - g0, idle);
    else passed++;
  endtask

  task automatic test_backpressure();
    beat_t e;
    int hs;
    int pat[5] = '{1, 0, 0, 1, 1};
    apply_reset();
    post_burst(1, 3, 32'h0000_00B0, 0);
    for (int c = 0; c < 6 && grant_o == '0; c++) @(negedge clk);
    hs = 0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (s_wready[1] !== m_wready || (s_wready & 4'b1101) !== 4'b0000)
        $display("FAIL bp_wready: s_wready=%b m_wready=%b required bit1 mirror, others 0",
                 s_wready, m_wready);
      else passed++;
      if (m_wvalid && m_wready) begin
        hs++;
        e = exp_q.pop_front();
        total++;
        if ({m_wdata, m_wstrb, m_wlast} !== {e.data, e.strb, e.last})
          $display("FAIL bp_beat: got d=%h s=%h l=%b required d=%h s=%h l=%b",
                   m_wdata, m_wstrb, m_wlast, e.data, e.strb, e.last);
        else passed++;
      end
      @(posedge clk);
      #1;
      if (k < 4) m_wready = pat[k+1][0];
      @(negedge clk);
    end
    m_wready = 1'b1;
    total++;
    if (hs != 3 || exp_q.size() != 0)
      $display("FAIL bp_count: handshakes=%0d left=%0d required 3/0", hs, exp_q.size());
    else passed++;
  endtask

  task automatic test_stall();
    beat_t e;
    int stall;
    apply_reset();
    post_burst(0, 3, 32'h0000_00C0, 5);
    post_burst(3, 1, 32'h0000_00D0, 0);
    stall = 0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (busy_o && !m_wvalid) begin
        stall++;
        total++;
        if (grant_o !== 4'b0001 || s_wready[3] !== 1'b0)
          $display("FAIL stall_hold: grant=%b s_wready=%b required 0001, bit3 0", grant_o, s_wready);
        else passed++;
      end
      if (m_wvalid && m_wready) begin
        e = exp_q.pop_front();
        total++;
        if ({m_wdata, m_wstrb, m_wlast, grant_o} !== {e.data, e.strb, e.last, e.gnt})
          $display("FAIL stall_beat: got d=%h l=%b g=%b required d=%h l=%b g=%b",
                   m_wdata, m_wlast, grant_o, e.data, e.last, e.gnt);
        else passed++;
      end
      @(negedge clk);
    end
    total++;
    if (stall != 5 || exp_q.size() != 0)
      $display("FAIL stall_count: stalled=%0d left=%0d required 5/0", stall, exp_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    post_burst(1, 8, 32'h0000_00E0, 0);
    for (int c = 0; c < 6 && grant_o == '0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({grant_o, busy_o, m_wvalid, m_wlast, m_wdata, m_wstrb, s_wready} !== '0)
      $display("FAIL reset_mid: grant=%b busy=%b m_wvalid=%b m_wdata=%h s_wready=%b required all 0",
               grant_o, busy_o, m_wvalid, m_wdata, s_wready);
    else passed++;
    apply_reset();
  endtask

  task automatic test_beat_limit();
    beat_t e;
    int n;
    apply_reset();
    post_burst(1, 5, 32'h0000_00F0, 0);
    n = 0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (m_wvalid && m_wready) begin
        e = exp_q.pop_front();
        total++;
        if (m_wdata !== e.data || m_wlast !== e.last || err_o !== (LIM && n >= 4))
          $display("FAIL limit_beat%0d: d=%h l=%b err=%b required d=%h l=%b err=%b",
                   n, m_wdata, m_wlast, err_o, e.data, e.last, LIM && n >= 4);
        else passed++;
        n++;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    total++;
    if (err_o !== LIM || n != 5)
      $display("FAIL limit_sticky: err=%b beats=%0d required %b/5", err_o, n, LIM);
    else passed++;
    apply_reset();
    @(negedge clk);
    total++;
    if (err_o !== 1'b0) $display("FAIL limit_clear: err=%b required 0", err_o);
    else passed++;
  endtask

  initial begin
    rst_n    = 1'b0;
    force_v  = 1'b0;
    m_wready = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_beat_limit();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
